// File: rtl/deadlock_pkg.sv
// rtl/deadlock_pkg.sv - shared state encoding and index helper for deadlock monitoring
package deadlock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Lowest set bit index of vec, or -1 when vec is empty.
   function automatic int first_set_idx(input logic [31:0] vec);
      int idx;
      idx = -1;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/deadlock_stall_counter.sv
// rtl/deadlock_stall_counter.sv - saturating stall counter with sticky detection flag
module deadlock_stall_counter #(
   parameter int STALL_CYCLES = 16,
   parameter int W = $clog2(STALL_CYCLES + 1)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         stall,
   output logic [W-1:0] count,
   output logic         detect
);

   localparam logic [W-1:0] LIMIT = W'(STALL_CYCLES);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         detect <= 1'b0;
      end else begin
         if (!stall)
            count <= '0;
         else if (count != LIMIT)
            count <= count + 1'b1;
         // flag rises on the same edge the count lands on LIMIT
         if (stall && (count >= LIMIT - 1'b1))
            detect <= 1'b1;
      end
   end

endmodule

// File: rtl/deadlock_proc_monitor.sv
// rtl/deadlock_proc_monitor.sv - per-process stall detection and token-passing cycle walk
module deadlock_proc_monitor
   import deadlock_pkg::*;
#(
   parameter int PROC_NUM     = 4,
   parameter int PROC_ID      = 0,
   parameter int STALL_CYCLES = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                proc_blocked,
   input  logic [PROC_NUM-1:0] dep_vec,
   input  logic [PROC_NUM-1:0] blocked_vec,
   input  logic                dl_detect_in,
   input  logic [PROC_NUM-1:0] origin,
   input  logic                token_clear,
   input  logic                token_in,
   output logic                dl_out,
   output logic [PROC_NUM-1:0] token_out_vec,
   output logic                dl_detect_local
);

   localparam int CW = $clog2(STALL_CYCLES + 1);

   logic                stall;
   logic [CW-1:0]       count;
   logic [PROC_NUM-1:0] succ_mask;
   logic [PROC_NUM-1:0] succ_onehot;
   int                  succ_idx;
   state_t              state;
   logic                is_origin;

   assign stall = proc_blocked && ((dep_vec & ~blocked_vec) == '0) && (dep_vec != '0);

   deadlock_stall_counter #(
      .STALL_CYCLES(STALL_CYCLES),
      .W           (CW)
   ) u_cnt (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .count (count),
      .detect(dl_detect_local)
   );

   // self-dependence never names a successor
   assign succ_mask = dep_vec & blocked_vec & ~(PROC_NUM'(1) << PROC_ID);
   assign succ_idx  = first_set_idx(32'(succ_mask));

   always_comb begin
      succ_onehot = '0;
      if (succ_idx >= 0) succ_onehot = PROC_NUM'(1) << succ_idx;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         is_origin     <= 1'b0;
         dl_out        <= 1'b0;
         token_out_vec <= '0;
      end else if (!dl_detect_in) begin
         state         <= ST_IDLE;
         is_origin     <= 1'b0;
         dl_out        <= dl_detect_local;
         token_out_vec <= '0;
      end else if (token_clear) begin
         state         <= ST_IDLE;
         is_origin     <= 1'b0;
         dl_out        <= 1'b0;
         token_out_vec <= '0;
      end else begin
         dl_out        <= 1'b0;
         token_out_vec <= '0;
         case (state)
            ST_IDLE: begin
               if (origin[PROC_ID]) begin
                  state         <= ST_HOLD;
                  is_origin     <= 1'b1;
                  token_out_vec <= succ_onehot;
               end else if (token_in) begin
                  state         <= ST_HOLD;
                  is_origin     <= 1'b0;
                  dl_out        <= 1'b1;
                  token_out_vec <= succ_onehot;
               end
            end
            ST_HOLD: state <= ST_WAIT;
            ST_WAIT: begin
               if (is_origin && token_in) dl_out <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deadlock_proc_monitor.sv
// tb/tb_deadlock_proc_monitor.sv - three-monitor ring bench for deadlock_proc_monitor
module tb_deadlock_proc_monitor;
   import deadlock_pkg::*;

   logic       clock;
   logic       reset;
   logic [2:0] blocked;
   logic [2:0] dep0, dep1, dep2;
   logic       dl_detect;
   logic [2:0] origin;
   logic       token_clear;
   logic [2:0] token_in;
   logic [2:0] dl_out;
   logic [2:0] local_det;
   logic [2:0] tov0, tov1, tov2;

   int compared = 0;
   int failed   = 0;

   assign token_in = tov0 | tov1 | tov2;

   deadlock_proc_monitor #(.PROC_NUM(3), .PROC_ID(0), .STALL_CYCLES(4)) u0 (
      .clock(clock), .reset(reset), .proc_blocked(blocked[0]), .dep_vec(dep0),
      .blocked_vec(blocked), .dl_detect_in(dl_detect), .origin(origin),
      .token_clear(token_clear), .token_in(token_in[0]), .dl_out(dl_out[0]),
      .token_out_vec(tov0), .dl_detect_local(local_det[0]));
   deadlock_proc_monitor #(.PROC_NUM(3), .PROC_ID(1), .STALL_CYCLES(4)) u1 (
      .clock(clock), .reset(reset), .proc_blocked(blocked[1]), .dep_vec(dep1),
      .blocked_vec(blocked), .dl_detect_in(dl_detect), .origin(origin),
      .token_clear(token_clear), .token_in(token_in[1]), .dl_out(dl_out[1]),
      .token_out_vec(tov1), .dl_detect_local(local_det[1]));
   deadlock_proc_monitor #(.PROC_NUM(3), .PROC_ID(2), .STALL_CYCLES(4)) u2 (
      .clock(clock), .reset(reset), .proc_blocked(blocked[2]), .dep_vec(dep2),
      .blocked_vec(blocked), .dl_detect_in(dl_detect), .origin(origin),
      .token_clear(token_clear), .token_in(token_in[2]), .dl_out(dl_out[2]),
      .token_out_vec(tov2), .dl_detect_local(local_det[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] blocked;
      logic [2:0] dep0;
      logic       exp_local;
      logic       exp_dl;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; blocked = '0; dep0 = '0; dep1 = '0; dep2 = '0;
      dl_detect = 1'b0; origin = '0; token_clear = 1'b0;

      // P0 waits on P1; 3 stalled cycles, release, then 4+ stalled cycles
      vecs[0]  = '{3'b011, 3'b010, 1'b0, 1'b0, 1};
      vecs[1]  = '{3'b011, 3'b010, 1'b0, 1'b0, 2};
      vecs[2]  = '{3'b011, 3'b010, 1'b0, 1'b0, 3};
      vecs[3]  = '{3'b001, 3'b010, 1'b0, 1'b0, 0};
      vecs[4]  = '{3'b011, 3'b110, 1'b0, 1'b0, 0};
      vecs[5]  = '{3'b011, 3'b010, 1'b0, 1'b0, 1};
      vecs[6]  = '{3'b011, 3'b010, 1'b0, 1'b0, 2};
      vecs[7]  = '{3'b011, 3'b010, 1'b0, 1'b0, 3};
      vecs[8]  = '{3'b011, 3'b010, 1'b1, 1'b0, 4};
      vecs[9]  = '{3'b011, 3'b010, 1'b1, 1'b1, 4};
      vecs[10] = '{3'b010, 3'b010, 1'b1, 1'b1, 0};
      vecs[11] = '{3'b001, 3'b000, 1'b1, 1'b1, 0};
      vecs[12] = '{3'b000, 3'b000, 1'b1, 1'b1, 0};

      step();
      chk("reset_dl_out", int'(dl_out), 0);
      chk("reset_tov0", int'(tov0), 0);
      chk("reset_local", int'(local_det), 0);
      chk("reset_cnt", int'(u0.u_cnt.count), 0);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         blocked = vecs[i].blocked;
         dep0    = vecs[i].dep0;
         step();
         chk($sformatf("det%0d_local", i), int'(local_det[0]), int'(vecs[i].exp_local));
         chk($sformatf("det%0d_dl_out", i), int'(dl_out[0]), int'(vecs[i].exp_dl));
         chk($sformatf("det%0d_cnt", i), int'(u0.u_cnt.count), vecs[i].exp_cnt);
      end

      // ring walk 0->1->2->0, origin presented in cycle t
      do_reset();
      dep0 = 3'b010; dep1 = 3'b100; dep2 = 3'b001; blocked = 3'b111;
      dl_detect = 1'b1;
      origin = 3'b001;
      step();                                            // t+1
      origin = 3'b000;
      chk("ring_t1_tov0", int'(tov0), 2);
      chk("ring_t1_dl", int'(dl_out), 0);
      chk("ring_t1_state0", int'(u0.state), int'(ST_HOLD));
      step();                                            // t+2
      chk("ring_t2_dl", int'(dl_out), 2);
      chk("ring_t2_tov1", int'(tov1), 4);
      chk("ring_t2_tov0", int'(tov0), 0);
      step();                                            // t+3
      chk("ring_t3_dl", int'(dl_out), 4);
      chk("ring_t3_tov2", int'(tov2), 1);
      step();                                            // t+4: origin closes
      chk("ring_t4_dl", int'(dl_out), 1);
      chk("ring_t4_tov", int'(tov0 | tov1 | tov2), 0);
      token_clear = 1'b1;
      step();                                            // t+5
      token_clear = 1'b0;
      chk("ring_t5_dl", int'(dl_out), 0);
      chk("ring_t5_state0", int'(u0.state), int'(ST_IDLE));
      chk("ring_t5_state1", int'(u1.state), int'(ST_IDLE));
      chk("ring_t5_state2", int'(u2.state), int'(ST_IDLE));
      step();
      chk("ring_t6_dl", int'(dl_out), 0);
      chk("ring_t6_tov", int'(tov0 | tov1 | tov2), 0);

      // token_clear while P1 holds the token
      origin = 3'b001;
      step();
      origin = 3'b000;
      step();
      chk("clr_p1_hold", int'(u1.state), int'(ST_HOLD));
      token_clear = 1'b1;
      step();
      token_clear = 1'b0;
      chk("clr_tov1", int'(tov1), 0);
      chk("clr_state1", int'(u1.state), int'(ST_IDLE));
      chk("clr_state2", int'(u2.state), int'(ST_IDLE));
      chk("clr_dl", int'(dl_out), 0);
      step();
      chk("clr_dl_after", int'(dl_out), 0);

      // origin with no successor drops the token and parks in WAIT
      dep0 = 3'b000;
      origin = 3'b001;
      step();
      origin = 3'b000;
      chk("nosucc_tov0", int'(tov0), 0);
      step();
      chk("nosucc_wait", int'(u0.state), int'(ST_WAIT));
      step();
      step();
      chk("nosucc_still_wait", int'(u0.state), int'(ST_WAIT));
      chk("nosucc_dl", int'(dl_out), 0);
      token_clear = 1'b1;
      step();
      token_clear = 1'b0;
      chk("nosucc_idle", int'(u0.state), int'(ST_IDLE));

      // asynchronous reset in the middle of a walk
      dep0 = 3'b010;
      origin = 3'b001;
      step();
      origin = 3'b000;
      step();
      chk("rst_mid_pre", int'(dl_out[1]), 1);
      reset = 1'b0;
      #1;
      chk("rst_mid_dl", int'(dl_out), 0);
      chk("rst_mid_tov", int'(tov0 | tov1 | tov2), 0);
      chk("rst_mid_local", int'(local_det), 0);
      chk("rst_mid_cnt", int'(u0.u_cnt.count), 0);
      chk("rst_mid_state1", int'(u1.state), int'(ST_IDLE));
      step();
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
